// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe_if
// Purpose  : Input/output handshake bundle and debug counter for imm_gen_pipe.
// Revision : 1.0
// ============================================================================
interface imm_gen_pipe_if #(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 5,
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [24:0]          instr;
    logic [2:0]           immsrc;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      immext;
    logic [TAG_W-1:0]     out_tag;
    logic                 out_illegal;
    logic                 err_clr;
    logic [ERR_CNT_W-1:0] err_count;

    modport slave (
        input  in_valid, instr, immsrc, in_tag, out_ready, err_clr,
        output in_ready, out_valid, immext, out_tag, out_illegal, err_count
    );

    modport master (
        output in_valid, instr, immsrc, in_tag, out_ready, err_clr,
        input  in_ready, out_valid, immext, out_tag, out_illegal, err_count
    );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Registered RV32I/RV64I immediate generator with 2-entry skid buffer.
// Revision : 1.0
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 5,
    parameter int ERR_CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    imm_gen_pipe_if.slave    bus
);
    localparam logic [ERR_CNT_W-1:0] C_ERR_MAX = '1;

    logic [31:7]     w_f;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic            w_ill;
    logic            w_in_xfer;
    logic            w_drain;

    logic                 out_valid_q, out_valid_d;
    logic [XLEN-1:0]      out_imm_q,   out_imm_d;
    logic [TAG_W-1:0]     out_tag_q,   out_tag_d;
    logic                 out_ill_q,   out_ill_d;
    logic                 sk_valid_q,  sk_valid_d;
    logic [XLEN-1:0]      sk_imm_q,    sk_imm_d;
    logic [TAG_W-1:0]     sk_tag_q,    sk_tag_d;
    logic                 sk_ill_q,    sk_ill_d;
    logic [ERR_CNT_W-1:0] err_q,       err_d;

    assign w_f   = bus.instr;
    assign w_ill = bus.immsrc[2] & bus.immsrc[1];

    always_comb begin
        w_imm32 = 32'b0;
        case (bus.immsrc)
            3'b000:  w_imm32 = {{20{w_f[31]}}, w_f[31:20]};
            3'b001:  w_imm32 = {{20{w_f[31]}}, w_f[31:25], w_f[11:7]};
            3'b010:  w_imm32 = {{19{w_f[31]}}, w_f[31], w_f[7], w_f[30:25], w_f[11:8], 1'b0};
            3'b011:  w_imm32 = {{11{w_f[31]}}, w_f[31], w_f[19:12], w_f[20], w_f[30:21], 1'b0};
            3'b100:  w_imm32 = {w_f[31:12], 12'b0};
            3'b101:  w_imm32 = {27'b0, w_f[19:15]};
            default: w_imm32 = 32'b0;
        endcase
    end

    // Every 32-bit result already carries its correct bit 31, so one sign extension covers all formats.
    if (XLEN == 64) begin : g_ext64
        assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_ext32
        assign w_imm = w_imm32;
    end

    assign w_in_xfer = bus.in_valid & ~sk_valid_q;
    assign w_drain   = out_valid_q & bus.out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_imm_d   = out_imm_q;
        out_tag_d   = out_tag_q;
        out_ill_d   = out_ill_q;
        sk_valid_d  = sk_valid_q;
        sk_imm_d    = sk_imm_q;
        sk_tag_d    = sk_tag_q;
        sk_ill_d    = sk_ill_q;
        err_d       = err_q;

        if (sk_valid_q) begin
            if (w_drain) begin
                out_imm_d  = sk_imm_q;
                out_tag_d  = sk_tag_q;
                out_ill_d  = sk_ill_q;
                sk_valid_d = 1'b0;
            end
        end else if (!out_valid_q || w_drain) begin
            out_valid_d = w_in_xfer;
            if (w_in_xfer) begin
                out_imm_d = w_imm;
                out_tag_d = bus.in_tag;
                out_ill_d = w_ill;
            end
        end else if (w_in_xfer) begin
            sk_valid_d = 1'b1;
            sk_imm_d   = w_imm;
            sk_tag_d   = bus.in_tag;
            sk_ill_d   = w_ill;
        end

        if (bus.err_clr) begin
            err_d = '0;
        end else if (w_in_xfer && w_ill && (err_q != C_ERR_MAX)) begin
            err_d = err_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_imm_q   <= '0;
            out_tag_q   <= '0;
            out_ill_q   <= 1'b0;
            sk_valid_q  <= 1'b0;
            sk_imm_q    <= '0;
            sk_tag_q    <= '0;
            sk_ill_q    <= 1'b0;
            err_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_imm_q   <= out_imm_d;
            out_tag_q   <= out_tag_d;
            out_ill_q   <= out_ill_d;
            sk_valid_q  <= sk_valid_d;
            sk_imm_q    <= sk_imm_d;
            sk_tag_q    <= sk_tag_d;
            sk_ill_q    <= sk_ill_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready    = ~sk_valid_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.immext      = out_imm_q;
    assign bus.out_tag     = out_tag_q;
    assign bus.out_illegal = out_ill_q;
    assign bus.err_count   = err_q;
endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, parametrised immediate generator for the decode stage of the pipelined core.
- Covers all RV32I/RV64I immediate formats plus the CSR zero-extended uimm.
- Sign-extends to XLEN and flags illegal format selects.
- Moves instructions through a valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops an instruction.
- Keeps a saturating count of illegal format selects for debug.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 5, width of the sideband tag carried alongside each immediate (e.g. rd index or ROB id).
- ERR_CNT_W, 8, width of the illegal-select counter.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block can accept this cycle.
- instr  in  25  instruction bits [31:7].
- immsrc  in  3  format select.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  immext/out_tag/out_illegal are valid.
- out_ready  in  1  downstream accepts.
- immext  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the presented entry.
- out_illegal  out  1  presented entry had an illegal immsrc.
- err_clr  in  1  synchronous clear of err_count.
- err_count  out  ERR_CNT_W  saturating count of accepted illegal selects.

Behaviour:
- Format decode. Each result is sign-extended from its top bit to XLEN unless marked otherwise.
  - 000 I: instr[31:20].
  - 001 S: {instr[31:25], instr[11:7]}.
  - 010 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 011 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 100 U: {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - 101 Z: zero-extended instr[19:15].
  - 110/111: immext=0, illegal=1.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Storage: output register (OUT) plus skid register (SK). Decode is combinational into whichever register captures.
- in_ready = ~sk_valid. It is a registered value, with no combinational path from out_ready.
- Latency: 1 cycle from input transfer to out_valid when OUT is empty or draining.
- Per-cycle rules:
  - OUT empty, or OUT draining with SK empty: an accepted input loads OUT.
  - OUT full, not draining, input accepted: input loads SK; sk_valid=1; in_ready=0 next cycle.
  - OUT draining with SK full: OUT<=SK; sk_valid=0. No input can be accepted that cycle.
  - OUT draining, no input, SK empty: out_valid=0 next cycle.
  - While out_valid=1 and out_ready=0, immext/out_tag/out_illegal are held stable.
- Ordering is strictly FIFO. Throughput is 1/cycle when out_ready is held high.
- err_count:
  - +1 on each input transfer with immsrc in {110,111}.
  - Saturates at 2^ERR_CNT_W-1; no wrap.
  - err_clr forces 0 next cycle and wins over a simultaneous increment.
- Reset (asynchronous, reset_n=0):
  - out_valid=0, sk_valid=0, in_ready=1.
  - immext=0, out_tag=0, out_illegal=0, err_count=0.
  - Entries in flight are discarded. First accept is possible on the first edge after deassertion.
- in_valid=0 cycles never alter OUT/SK contents or err_count.

Test Plan:
1. XLEN=32, out_ready=1, instr[31:7] from 0xFFF00093, immsrc=000 -> next cycle out_valid=1, immext=0xFFFFFFFF. Then 0x800000B7, immsrc=100 -> immext=0x80000000.
2. XLEN=64, B-type from 0xFE000EE3 (offset -4), immsrc=010 -> immext=0xFFFFFFFFFFFFFFFC. U from 0x800000B7 -> 0xFFFFFFFF80000000. Z with instr[19:15]=5'h1F -> 0x1F.
3. Back-pressure: stream tags 1,2,3,4 with out_ready=0 from cycle 2.
   - OUT holds tag1, SK holds tag2, in_ready=0, tags 3/4 wait upstream.
   - Release out_ready -> outputs appear in order 1,2,3,4 with no loss or duplication.
   - immext is stable while stalled.
4. Illegal: three accepted immsrc=111 -> out_illegal=1, immext=0, err_count=3. Assert err_clr together with a fourth illegal -> err_count=0. With ERR_CNT_W=2, six illegals -> err_count=3.
5. Reset mid-operation: OUT and SK full, pull reset_n low between edges -> immediately out_valid=0, in_ready=1, err_count=0. After release, a new instruction arrives 1 cycle after acceptance.
6. Full-rate: 100 random instructions with random in_valid/out_ready -> scoreboard matches the decode table for every format and tag. Throughput is 1/cycle whenever both handshakes are held high.
